// File: rtl/imem_boot_loader.sv
// Boot loader: assembles big-endian words from a byte stream into instruction memory, holding the core in reset until the image is written.
// Optional trailing checksum check compiled in with `define LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN,
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = S_CHK;
`else
  localparam state_t PAYLOAD_END = S_FIN;
`endif

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic [15:0]       n_next;
  logic [31:0]       word_nxt;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       acc;
`endif

  assign accept    = in_valid & in_ready;
  assign n_next    = {shift[7:0], in_data};
  assign word_nxt  = {shift, in_data};
  assign last_word = ((words_loaded + (ADDR_W+1)'(1)) == count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_rst   = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    unique case (state)
      S_HDR: begin
        in_ready = 1'b1;
        if (accept && byte_cnt[0]) begin
          if (int'(n_next) > DEPTH) state_nxt = S_ERR;
          else if (n_next == 16'd0) state_nxt = PAYLOAD_END;
          else                      state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (accept && byte_cnt == 2'd3 && last_word) state_nxt = PAYLOAD_END;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (accept && byte_cnt == 2'd3) state_nxt = (word_nxt == acc) ? S_FIN : S_ERR;
      end
`endif
      S_FIN:  state_nxt = S_DONE;
      S_DONE: begin
        cpu_rst   = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:  load_err = 1'b1;
      default: state_nxt = S_HDR;
    endcase
    // reload wins over any byte handshaken on the same edge
    if (reload) state_nxt = S_HDR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt     <= '0;
      shift        <= '0;
      count        <= '0;
      addr         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_din     <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        byte_cnt     <= '0;
        shift        <= '0;
        count        <= '0;
        addr         <= '0;
        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
        acc          <= '0;
`endif
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[15:0], in_data};
        if (state == S_HDR && byte_cnt[0]) begin
          count    <= (ADDR_W+1)'(n_next);
          byte_cnt <= '0;
        end
        if (state == S_LOAD && byte_cnt == 2'd3) begin
          imem_we      <= 1'b1;
          imem_addr    <= addr;
          imem_din     <= word_nxt;
          addr         <= addr + ADDR_W'(1);
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          acc          <= acc + word_nxt;
`endif
        end
      end
    end
  end

endmodule
